// File: rtl/rf2_32x128_wm1_model.sv
// rtl/rf2_32x128_wm1_model.sv - two-port 32x128 register file with per-bit write mask
// Single-clock behavioural equivalent of the rf2_32x128_wm1 macro (port A read, port B write).
module rf2_32x128_wm1_model #(
  parameter int WORDS  = 32,
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CENA,
  input  logic [ADDR_W-1:0] AA,
  output logic [WIDTH-1:0]  QA,
  input  logic              CENB,
  input  logic [WIDTH-1:0]  WENB,
  input  logic [ADDR_W-1:0] AB,
  input  logic [WIDTH-1:0]  DB,
  input  logic              TENA,
  input  logic              TCENA,
  input  logic [ADDR_W-1:0] TAA,
  input  logic              TENB,
  input  logic              TCENB,
  input  logic [WIDTH-1:0]  TWENB,
  input  logic [ADDR_W-1:0] TAB,
  input  logic [WIDTH-1:0]  TDB,
  input  logic [2:0]        EMAA,
  input  logic              EMASA,
  input  logic [2:0]        EMAB,
  input  logic              RET1N,
  input  logic              COLLDISN,
  output logic              CENYA,
  output logic [ADDR_W-1:0] AYA,
  output logic              CENYB,
  output logic [WIDTH-1:0]  WENYB,
  output logic [ADDR_W-1:0] AYB
);

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [WIDTH-1:0] mem_d [WORDS];
  logic [WIDTH-1:0] qa_q;
  logic [WIDTH-1:0] qa_d;

  logic             cen_a;
  logic             cen_b;
  logic [WIDTH-1:0] db_sel;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;
  logic             unused_ema;

  // Margin-adjust pins only tune the hard macro's timing; they have no function here.
  assign unused_ema = ^{EMAA, EMASA, EMAB};

  // Retention (RET1N=0) parks both ports by forcing the enables inactive.
  always_comb begin
    AYA    = TENA ? AA : TAA;
    AYB    = TENB ? AB : TAB;
    WENYB  = TENB ? WENB : TWENB;
    db_sel = TENB ? DB : TDB;
    cen_a  = TENA ? CENA : TCENA;
    cen_b  = TENB ? CENB : TCENB;
    CENYA  = RET1N ? cen_a : 1'b1;
    CENYB  = RET1N ? cen_b : 1'b1;
  end

  always_comb begin
    mem_d   = mem_q;
    qa_d    = qa_q;
    wr_word = (mem_q[AYB] & WENYB) | (db_sel & ~WENYB);
    rd_word = mem_q[AYA];
    if (!CENYB) begin
      mem_d[AYB] = wr_word;
    end
    if (!CENYA) begin
      // Same-address collision: write-through only when collision detection is disabled.
      if (!CENYB && (AYA == AYB) && !COLLDISN) begin
        rd_word = wr_word;
      end
      qa_d = rd_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qa_q <= '0;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      qa_q <= qa_d;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign QA = qa_q;

endmodule

// File: tb/tb_rf2_32x128_wm1_model.sv
// tb/tb_rf2_32x128_wm1_model.sv - scoreboard bench for rf2_32x128_wm1_model
// Reference model keeps the array as plain bit vectors and applies the read/write rules per bit.
module tb_rf2_32x128_wm1_model;
  localparam int W = 128;
  localparam int A = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          CENA, CENB, TENA, TCENA, TENB, TCENB, EMASA, RET1N, COLLDISN;
  logic [A-1:0]  AA, AB, TAA, TAB;
  logic [W-1:0]  WENB, DB, TWENB, TDB;
  logic [2:0]    EMAA, EMAB;
  logic [W-1:0]  QA, WENYB;
  logic          CENYA, CENYB;
  logic [A-1:0]  AYA, AYB;

  rf2_32x128_wm1_model dut (
    .clk(clk), .reset(reset), .CENA(CENA), .AA(AA), .QA(QA), .CENB(CENB), .WENB(WENB),
    .AB(AB), .DB(DB), .TENA(TENA), .TCENA(TCENA), .TAA(TAA), .TENB(TENB), .TCENB(TCENB),
    .TWENB(TWENB), .TAB(TAB), .TDB(TDB), .EMAA(EMAA), .EMASA(EMASA), .EMAB(EMAB),
    .RET1N(RET1N), .COLLDISN(COLLDISN), .CENYA(CENYA), .AYA(AYA), .CENYB(CENYB),
    .WENYB(WENYB), .AYB(AYB)
  );

  logic [W-1:0] mdl_mem [32];
  logic [W-1:0] mdl_qa;
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("qa_scoreboard", QA, exp_q.pop_front());
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
    mdl_qa = '0;
  endtask

  task automatic idle();
    CENA = 1; CENB = 1; WENB = '1; AA = '0; AB = '0; DB = '0;
    TENA = 1; TENB = 1; TCENA = 1; TCENB = 1; TAA = '0; TAB = '0; TWENB = '1; TDB = '0;
    RET1N = 1; COLLDISN = 1;
  endtask

  // One clock: check the test-mux outputs, then model the edge and queue the expected QA.
  task automatic step();
    logic          ea, eb;
    logic [A-1:0]  ra, wa;
    logic [W-1:0]  m, d, rd;
    EMAA = 3'($urandom); EMAB = 3'($urandom); EMASA = 1'($urandom);
    #1;
    ra = TENA ? AA : TAA;
    wa = TENB ? AB : TAB;
    m  = TENB ? WENB : TWENB;
    d  = TENB ? DB : TDB;
    ea = RET1N ? (TENA ? CENA : TCENA) : 1'b1;
    eb = RET1N ? (TENB ? CENB : TCENB) : 1'b1;
    chk("cenya", W'(CENYA), W'(ea));
    chk("aya", W'(AYA), W'(ra));
    chk("cenyb", W'(CENYB), W'(eb));
    chk("wenyb", WENYB, m);
    chk("ayb", W'(AYB), W'(wa));
    @(posedge clk);
    if (!reset) begin
      if (!ea) begin
        rd = mdl_mem[ra];
        if (!eb && ra == wa && !COLLDISN)
          for (int i = 0; i < W; i++) if (!m[i]) rd[i] = d[i];
        mdl_qa = rd;
      end
      if (!eb)
        for (int i = 0; i < W; i++) if (!m[i]) mdl_mem[wa][i] = d[i];
    end
    exp_q.push_back(mdl_qa);
    @(negedge clk);
  endtask

  task automatic rd(input logic [A-1:0] a);
    idle(); CENA = 0; AA = a; step();
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
    idle(); CENB = 0; AB = a; DB = d; WENB = m; step();
  endtask

  logic [W-1:0] va, vb, vx;

  initial begin
    idle();
    EMAA = '0; EMAB = '0; EMASA = 0;
    reset = 1;
    model_clear();
    @(negedge clk);
    #1 chk("reset_qa", QA, '0);
    @(negedge clk);
    reset = 0;

    rd(5'h0a);
    chk("read_after_reset", QA, '0);

    wr(5'h0a, 128'h0000_0002_0000_0002_0000_0002_0000_0002, {{96{1'b1}}, 32'h0});
    idle(); step();
    rd(5'h0a);
    chk("masked_low_word", QA, 128'h2);

    va = {4{32'hDEADBEEF}};
    wr(5'h1f, va, '0);
    wr(5'h1f, 128'h01234567_89ABCDEF_FEDCBA98_76543210, {32'h0, {96{1'b1}}});
    rd(5'h1f);
    chk("upper_word_only", QA, {32'h01234567, {3{32'hDEADBEEF}}});

    va = 128'hAAAA_5555_0F0F_F0F0_1234_5678_9ABC_DEF0;
    vb = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    wr(5'h03, va, '0);
    idle(); CENA = 0; AA = 5'h03; CENB = 0; AB = 5'h03; DB = vb; WENB = '0; COLLDISN = 1; step();
    chk("collision_rbw", QA, va);
    rd(5'h03);
    chk("collision_rbw_after", QA, vb);
    wr(5'h03, va, '0);
    idle(); CENA = 0; AA = 5'h03; CENB = 0; AB = 5'h03; DB = vb; WENB = '0; COLLDISN = 0; step();
    chk("collision_wt", QA, vb);
    rd(5'h03);
    chk("collision_wt_after", QA, vb);

    vx = 128'hCAFEF00D_0BADC0DE_13579BDF_2468ACE0;
    idle(); TENA = 0; TENB = 0; TCENB = 0; TAB = 5'h05; TDB = vx; TWENB = '0; step();
    idle(); TENA = 0; TENB = 0; TCENA = 0; TAA = 5'h05; AA = 5'h1f; step();
    chk("test_mux_roundtrip", QA, vx);

    idle(); RET1N = 0; CENB = 0; AB = 5'h05; DB = ~vx; WENB = '0; CENA = 0; AA = 5'h1f; step();
    chk("retention_qa_held", QA, vx);
    rd(5'h05);
    chk("retention_no_write", QA, vx);

    rd(5'h1f);
    #2 reset = 1;
    #1 chk("async_reset_qa", QA, '0);
    model_clear();
    idle(); CENB = 0; AB = 5'h0a; DB = '1; WENB = '0; CENA = 0; AA = 5'h1f; step();
    reset = 0;
    rd(5'h1f);
    chk("cleared_1f", QA, '0);
    rd(5'h0a);
    chk("cleared_0a", QA, '0);

    for (int n = 0; n < 400; n++) begin
      idle();
      CENA = ($urandom_range(3) == 0);
      CENB = ($urandom_range(3) == 0);
      AA = 5'($urandom_range(7)); AB = 5'($urandom_range(7));
      DB = {$urandom, $urandom, $urandom, $urandom};
      WENB = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) WENB = '0;
      TENA = ($urandom_range(7) != 0); TENB = ($urandom_range(7) != 0);
      TCENA = 1'($urandom); TCENB = 1'($urandom);
      TAA = 5'($urandom_range(7)); TAB = 5'($urandom_range(7));
      TDB = {$urandom, $urandom, $urandom, $urandom};
      TWENB = {$urandom, $urandom, $urandom, $urandom};
      RET1N = ($urandom_range(15) != 0);
      COLLDISN = 1'($urandom);
      step();
    end

    idle();
    for (int n = 0; n < 32; n++) rd(5'(n));
    for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
